branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 92 +++++++++
 tb/tb_branch_predictor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: untagged table of 2-bit saturating counters,
// misprediction recovery PC, and saturating branch/misprediction statistics.
module branch_predictor #(
   parameter int IDX_BITS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] fetch_pc,
   output logic        prediction,
   input  logic        ex_valid,
   input  logic        ex_branch,
   input  logic        ex_taken,
   input  logic        ex_pred,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        hlt,
   output logic        wrong,
   output logic [31:0] correct_pc,
   output logic [15:0] br_count,
   output logic [15:0] mp_count
);

   localparam int ENTRIES = 1 << IDX_BITS;

   localparam logic [1:0] WEAK_NT   = 2'b01;
   localparam logic [1:0] STRONG_T  = 2'b11;
   localparam logic [1:0] STRONG_NT = 2'b00;

   logic [1:0]          pht_q [ENTRIES];
   logic [1:0]          pht_d [ENTRIES];
   logic [15:0]         br_count_q;
   logic [15:0]         br_count_d;
   logic [15:0]         mp_count_q;
   logic [15:0]         mp_count_d;

   logic [IDX_BITS-1:0] fetch_idx;
   logic [IDX_BITS-1:0] ex_idx;
   logic                resolve;
   logic [1:0]          ex_ctr;
   logic [1:0]          ex_ctr_next;
   logic [31:0]         ex_pc_plus4;

   assign fetch_idx = fetch_pc[IDX_BITS+1:2];
   assign ex_idx    = ex_pc[IDX_BITS+1:2];

   // Lookup reads the registered table only: no same-cycle bypass.
   assign prediction = pht_q[fetch_idx][1];

   assign resolve     = ex_valid & ex_branch & ~hlt;
   assign wrong       = resolve & (ex_pred != ex_taken);
   assign ex_pc_plus4 = ex_pc + 32'd4;
   assign correct_pc  = (wrong && ex_taken) ? ex_target : ex_pc_plus4;

   assign ex_ctr = pht_q[ex_idx];

   always_comb begin
      ex_ctr_next = ex_ctr;
      if (ex_taken) begin
         if (ex_ctr != STRONG_T) ex_ctr_next = ex_ctr + 2'd1;
      end else begin
         if (ex_ctr != STRONG_NT) ex_ctr_next = ex_ctr - 2'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) pht_d[i] = pht_q[i];
      if (resolve) pht_d[ex_idx] = ex_ctr_next;
   end

   always_comb begin
      br_count_d = br_count_q;
      mp_count_d = mp_count_q;
      if (resolve && br_count_q != 16'hFFFF) br_count_d = br_count_q + 16'd1;
      if (wrong && mp_count_q != 16'hFFFF) mp_count_d = mp_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) pht_q[i] <= WEAK_NT;
         br_count_q <= '0;
         mp_count_q <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) pht_q[i] <= pht_d[i];
         br_count_q <= br_count_d;
         mp_count_q <= mp_count_d;
      end
   end

   assign br_count = br_count_q;
   assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] fetch_pc;
   logic        prediction;
   logic        ex_valid;
   logic        ex_branch;
   logic        ex_taken;
   logic        ex_pred;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic        hlt;
   logic        wrong;
   logic [31:0] correct_pc;
   logic [15:0] br_count;
   logic [15:0] mp_count;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.IDX_BITS(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_pc   (fetch_pc),
      .prediction (prediction),
      .ex_valid   (ex_valid),
      .ex_branch  (ex_branch),
      .ex_taken   (ex_taken),
      .ex_pred    (ex_pred),
      .ex_pc      (ex_pc),
      .ex_target  (ex_target),
      .hlt        (hlt),
      .wrong      (wrong),
      .correct_pc (correct_pc),
      .br_count   (br_count),
      .mp_count   (mp_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic res(input logic [31:0] pc, input logic tk,
                      input logic pr);
      ex_valid  = 1'b1;
      ex_branch = 1'b1;
      ex_pc     = pc;
      ex_taken  = tk;
      ex_pred   = pr;
      #1;
   endtask

   task automatic idle();
      ex_valid  = 1'b0;
      ex_branch = 1'b0;
      #1;
   endtask

   task automatic pred_at(input string tag, input logic [31:0] pc,
                          input logic exp);
      fetch_pc = pc;
      #1;
      chk(tag, {31'd0, prediction}, {31'd0, exp});
   endtask

   initial begin
      rst_n     = 1'b0;
      fetch_pc  = 32'h40;
      ex_valid  = 1'b0;
      ex_branch = 1'b0;
      ex_taken  = 1'b0;
      ex_pred   = 1'b0;
      ex_pc     = 32'h0;
      ex_target = 32'h1000;
      hlt       = 1'b0;
      #2;
      pred_at("rst_pred_40", 32'h40, 1'b0);
      pred_at("rst_pred_ffc", 32'hFFC, 1'b0);
      chk("rst_br", {16'd0, br_count}, 32'd0);
      chk("rst_mp", {16'd0, mp_count}, 32'd0);
      chk("rst_wrong", {31'd0, wrong}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fetch_pc = 32'h40;

      // two taken resolves with ex_pred=0
      res(32'h40, 1'b1, 1'b0);
      chk("t1_wrong", {31'd0, wrong}, 32'd1);
      chk("t1_cpc", correct_pc, 32'h1000);
      tick();
      pred_at("t1_pred", 32'h40, 1'b1);
      res(32'h40, 1'b1, 1'b0);
      chk("t2_wrong", {31'd0, wrong}, 32'd1);
      tick();
      idle();
      pred_at("t2_pred", 32'h40, 1'b1);
      chk("t2_br", {16'd0, br_count}, 32'd2);
      chk("t2_mp", {16'd0, mp_count}, 32'd2);

      // three not-taken from 11 with ex_pred=1
      res(32'h40, 1'b0, 1'b1);
      chk("n1_cpc", correct_pc, 32'h44);
      chk("n1_wrong", {31'd0, wrong}, 32'd1);
      tick();
      pred_at("n1_pred", 32'h40, 1'b1);
      res(32'h40, 1'b0, 1'b1);
      chk("n2_cpc", correct_pc, 32'h44);
      tick();
      pred_at("n2_pred", 32'h40, 1'b0);
      res(32'h40, 1'b0, 1'b1);
      chk("n3_cpc", correct_pc, 32'h44);
      tick();
      pred_at("n3_pred", 32'h40, 1'b0);
      res(32'h40, 1'b0, 1'b0);
      chk("n4_wrong", {31'd0, wrong}, 32'd0);
      chk("n4_cpc", correct_pc, 32'h44);
      tick();
      chk("n4_br", {16'd0, br_count}, 32'd6);
      chk("n4_mp", {16'd0, mp_count}, 32'd5);
      // one taken from saturated 00 must reach only 01
      res(32'h40, 1'b1, 1'b1);
      chk("s1_cpc", correct_pc, 32'h44);
      tick();
      pred_at("s1_pred", 32'h40, 1'b0);
      res(32'h40, 1'b1, 1'b1);
      tick();
      idle();
      pred_at("s2_pred", 32'h40, 1'b1);

      // aliasing: 0x80 and 0x40 share index 0; entry is 10
      fetch_pc = 32'h40;
      res(32'h80, 1'b0, 1'b1);
      chk("al1_same", {31'd0, prediction}, 32'd1);
      tick();
      chk("al1_next", {31'd0, prediction}, 32'd0);
      res(32'h80, 1'b1, 1'b0);
      chk("al2_same", {31'd0, prediction}, 32'd0);
      tick();
      chk("al2_next", {31'd0, prediction}, 32'd1);
      idle();
      pred_at("al_other", 32'h44, 1'b0);
      chk("al_br", {16'd0, br_count}, 32'd10);
      chk("al_mp", {16'd0, mp_count}, 32'd7);

      // recovery PC wraps
      res(32'hFFFF_FFFC, 1'b0, 1'b1);
      chk("wrap_cpc", correct_pc, 32'h0);
      chk("wrap_wrong", {31'd0, wrong}, 32'd1);
      tick();
      idle();

      // halt freezes everything
      hlt = 1'b1;
      res(32'h40, 1'b0, 1'b1);
      chk("hlt_wrong", {31'd0, wrong}, 32'd0);
      tick();
      pred_at("hlt_pred", 32'h40, 1'b1);
      chk("hlt_br", {16'd0, br_count}, 32'd11);
      chk("hlt_mp", {16'd0, mp_count}, 32'd8);
      hlt = 1'b0;

      // non-branch does nothing
      res(32'h40, 1'b0, 1'b1);
      ex_branch = 1'b0;
      #1;
      chk("jmp_wrong", {31'd0, wrong}, 32'd0);
      tick();
      pred_at("jmp_pred", 32'h40, 1'b1);
      chk("jmp_br", {16'd0, br_count}, 32'd11);
      chk("jmp_mp", {16'd0, mp_count}, 32'd8);

      // br_count saturation
      res(32'h108, 1'b1, 1'b1);
      for (int i = 0; i < 65535; i++) @(posedge clk);
      #1;
      chk("sat_br", {16'd0, br_count}, 32'hFFFF);
      chk("sat_mp", {16'd0, mp_count}, 32'd8);
      tick();
      chk("sat_br2", {16'd0, br_count}, 32'hFFFF);
      pred_at("sat_pred", 32'h108, 1'b1);

      // async reset mid-cycle, held across an edge with resolve pending
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_br", {16'd0, br_count}, 32'd0);
      chk("arst_mp", {16'd0, mp_count}, 32'd0);
      pred_at("arst_pred108", 32'h108, 1'b0);
      pred_at("arst_pred40", 32'h40, 1'b0);
      tick();
      chk("arst_hold_br", {16'd0, br_count}, 32'd0);
      pred_at("arst_hold_pred", 32'h108, 1'b0);
      rst_n = 1'b1;
      res(32'h40, 1'b1, 1'b0);
      tick();
      idle();
      pred_at("post_pred", 32'h40, 1'b1);
      chk("post_br", {16'd0, br_count}, 32'd1);
      chk("post_mp", {16'd0, mp_count}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
